// File: rtl/sprite_pkg.sv
// Shared sprite constants, FSM encoding and bit-index helper for sprite readers.
package sprite_pkg;

  localparam int SPRITE_DIM  = 5;
  localparam int SPRITE_BITS = SPRITE_DIM * SPRITE_DIM;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DRAW = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Row-major pixel k lives at bit SPRITE_BITS-1-k (bit 24 is top-left).
  function automatic logic [4:0] bit_index(input logic [2:0] row, input logic [2:0] col);
    int k;
    k = int'(row) * SPRITE_DIM + int'(col);
    return 5'(SPRITE_BITS - 1 - k);
  endfunction

endpackage

// File: rtl/sprite_plotter_if.sv
// Sprite request / framebuffer pixel port bundle between the animation logic and the plotter.
interface sprite_plotter_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
);

  logic                start;
  logic [24:0]         sprite;
  logic [X_W-1:0]      x_origin;
  logic [Y_W-1:0]      y_origin;
  logic [COLOUR_W-1:0] fg_colour;
  logic [COLOUR_W-1:0] bg_colour;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                busy;
  logic                done;

  modport master (
    output start, sprite, x_origin, y_origin, fg_colour, bg_colour,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, sprite, x_origin, y_origin, fg_colour, bg_colour,
    output x, y, colour, plot, busy, done
  );

endinterface

// File: rtl/sprite_scan_counter.sv
// Row-major 5x5 scan counter with clear, enable, look-ahead position and last-pixel flag.
module sprite_scan_counter
  import sprite_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_en,
  output logic [2:0] o_row_nxt,
  output logic [2:0] o_col_nxt,
  output logic       o_last
);

  logic [2:0] r_row;
  logic [2:0] r_col;
  logic       w_col_end;

  assign w_col_end = (r_col == 3'(SPRITE_DIM - 1));
  assign o_last    = w_col_end && (r_row == 3'(SPRITE_DIM - 1));
  assign o_col_nxt = w_col_end ? 3'd0 : r_col + 3'd1;
  assign o_row_nxt = w_col_end ? r_row + 3'd1 : r_row;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_row <= 3'd0;
      r_col <= 3'd0;
    end else if (i_clr) begin
      r_row <= 3'd0;
      r_col <= 3'd0;
    end else if (i_en) begin
      r_row <= o_row_nxt;
      r_col <= o_col_nxt;
    end
  end

endmodule

// File: rtl/sprite_plotter.sv
// Serialises a latched 5x5 sprite into one registered framebuffer pixel write per clock.
// Optional build macro SPRITE_TRANSPARENT_EN: clear sprite bits are skipped (plot=0) instead of drawn in bg_colour.
module sprite_plotter
  import sprite_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) (
  input  logic            clock,
  input  logic            reset,
  sprite_plotter_if.slave bus
);

  logic [1:0]            r_state;
  logic [SPRITE_BITS-1:0] r_sprite;
  logic [X_W-1:0]        r_xo;
  logic [Y_W-1:0]        r_yo;
  logic [COLOUR_W-1:0]   r_fg;
  logic [COLOUR_W-1:0]   r_bg;
  logic [X_W-1:0]        r_x;
  logic [Y_W-1:0]        r_y;
  logic [COLOUR_W-1:0]   r_colour;
  logic                  r_plot;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_clr;
  logic                  w_adv;
  logic                  w_last;
  logic [2:0]            w_row_nxt;
  logic [2:0]            w_col_nxt;
  logic                  w_bit_first;
  logic                  w_bit_nxt;
  logic                  w_plot_first;
  logic                  w_plot_nxt;
  logic [COLOUR_W-1:0]   w_colour_first;
  logic [COLOUR_W-1:0]   w_colour_nxt;
  logic [X_W-1:0]        w_x_nxt;
  logic [Y_W-1:0]        w_y_nxt;

  assign w_clr = (r_state == ST_IDLE) && bus.start;
  assign w_adv = (r_state == ST_DRAW) && !w_last;

  sprite_scan_counter u_scan (
    .clock     (clock),
    .reset     (reset),
    .i_clr     (w_clr),
    .i_en      (w_adv),
    .o_row_nxt (w_row_nxt),
    .o_col_nxt (w_col_nxt),
    .o_last    (w_last)
  );

  // Pixel 0 is registered straight from the request inputs at the accepting edge.
  assign w_bit_first = bus.sprite[SPRITE_BITS-1];
  assign w_bit_nxt   = r_sprite[bit_index(w_row_nxt, w_col_nxt)];
  assign w_x_nxt     = r_xo + X_W'(w_col_nxt);
  assign w_y_nxt     = r_yo + Y_W'(w_row_nxt);

`ifdef SPRITE_TRANSPARENT_EN
  assign w_plot_first   = w_bit_first;
  assign w_plot_nxt     = w_bit_nxt;
  assign w_colour_first = bus.fg_colour;
  assign w_colour_nxt   = r_fg;
`else
  assign w_plot_first   = 1'b1;
  assign w_plot_nxt     = 1'b1;
  assign w_colour_first = w_bit_first ? bus.fg_colour : bus.bg_colour;
  assign w_colour_nxt   = w_bit_nxt ? r_fg : r_bg;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_sprite <= '0;
      r_xo     <= '0;
      r_yo     <= '0;
      r_fg     <= '0;
      r_bg     <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_sprite <= bus.sprite;
            r_xo     <= bus.x_origin;
            r_yo     <= bus.y_origin;
            r_fg     <= bus.fg_colour;
            r_bg     <= bus.bg_colour;
            r_state  <= ST_DRAW;
            r_busy   <= 1'b1;
            r_plot   <= w_plot_first;
            if (w_plot_first) begin
              r_x      <= bus.x_origin;
              r_y      <= bus.y_origin;
              r_colour <= w_colour_first;
            end
          end
        end
        ST_DRAW: begin
          if (w_last) begin
            r_state <= ST_DONE;
            r_plot  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_plot <= w_plot_nxt;
            // Skipped pixels leave x/y/colour at the last plotted values.
            if (w_plot_nxt) begin
              r_x      <= w_x_nxt;
              r_y      <= w_y_nxt;
              r_colour <= w_colour_nxt;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_plot  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x      = r_x;
  assign bus.y      = r_y;
  assign bus.colour = r_colour;
  assign bus.plot   = r_plot;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed self-checking bench for sprite_plotter (default build, opaque background).
module tb_sprite_plotter;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   plot_cnt;
  int   done_cnt;

  sprite_plotter_if #(.X_W(8), .Y_W(7), .COLOUR_W(3)) bus ();

  sprite_plotter #(.X_W(8), .Y_W(7), .COLOUR_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requests a draw at the next rising edge (T0) and checks cycles 1..27 after it.
  task automatic draw(input logic [24:0] spr, input logic [7:0] xo, input logic [6:0] yo,
                      input logic [2:0] fg, input logic [2:0] bg,
                      input bit pulse_mid, input bit hold);
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    int         k;
    ex = '0; ey = '0; ec = '0;
    @(negedge clock);
    bus.start     = 1'b1;
    bus.sprite    = spr;
    bus.x_origin  = xo;
    bus.y_origin  = yo;
    bus.fg_colour = fg;
    bus.bg_colour = bg;
    @(posedge clock);
    #1;
    if (!hold) bus.start = 1'b0;
    bus.sprite    = ~spr;
    bus.x_origin  = xo + 8'd3;
    bus.y_origin  = yo + 7'd3;
    bus.fg_colour = ~fg;
    bus.bg_colour = ~bg;
    for (int n = 1; n <= 27; n++) begin
      @(negedge clock);
      if (n <= 25) begin
        k  = n - 1;
        ex = xo + 8'(k % 5);
        ey = yo + 7'(k / 5);
        ec = spr[24-k] ? fg : bg;
      end
      chk("plot",   {31'd0, bus.plot}, {31'd0, n <= 25});
      chk("busy",   {31'd0, bus.busy}, {31'd0, n <= 26});
      chk("done",   {31'd0, bus.done}, {31'd0, n == 26});
      chk("x",      {24'd0, bus.x},      {24'd0, ex});
      chk("y",      {25'd0, bus.y},      {25'd0, ey});
      chk("colour", {29'd0, bus.colour}, {29'd0, ec});
      if (pulse_mid && n == 5) bus.start = 1'b1;
      if (pulse_mid && n == 6) bus.start = 1'b0;
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.sprite    = '0;
    bus.x_origin  = '0;
    bus.y_origin  = '0;
    bus.fg_colour = '0;
    bus.bg_colour = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_x",      {24'd0, bus.x}, 32'd0);
    chk("rst_y",      {25'd0, bus.y}, 32'd0);
    chk("rst_colour", {29'd0, bus.colour}, 32'd0);
    chk("rst_plot",   {31'd0, bus.plot}, 32'd0);
    chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
    chk("rst_done",   {31'd0, bus.done}, 32'd0);
    reset = 1'b0;

    draw(25'h1FFFFFF, 8'd10, 7'd20, 3'b110, 3'b000, 1'b0, 1'b0);
    draw(25'b0111011111110001111101110, 8'd40, 7'd50, 3'd6, 3'd0, 1'b0, 1'b0);
    draw(25'b0111011111110001111101110, 8'd158, 7'd118, 3'd5, 3'd2, 1'b0, 1'b0);
    draw(25'h1555555, 8'd254, 7'd126, 3'd7, 3'd1, 1'b0, 1'b0);
    draw(25'h0F0F0F0, 8'd30, 7'd30, 3'd3, 3'd4, 1'b1, 1'b0);

    // Held start: second draw accepted at T0+27 using the inputs present then.
    draw(25'h1234567, 8'd60, 7'd60, 3'd2, 3'd5, 1'b0, 1'b1);
    @(negedge clock);
    chk("b2b_plot",   {31'd0, bus.plot}, 32'd1);
    chk("b2b_busy",   {31'd0, bus.busy}, 32'd1);
    chk("b2b_x",      {24'd0, bus.x}, 32'd63);
    chk("b2b_y",      {25'd0, bus.y}, 32'd63);
    chk("b2b_colour", {29'd0, bus.colour}, 32'd2);
    bus.start = 1'b0;
    repeat (30) @(negedge clock);
    chk("b2b_idle", {31'd0, bus.busy}, 32'd0);

    // Reset while pixel 12 is on the outputs.
    @(negedge clock);
    bus.start     = 1'b1;
    bus.sprite    = 25'h1FFFFFF;
    bus.x_origin  = 8'd5;
    bus.y_origin  = 7'd5;
    bus.fg_colour = 3'd4;
    bus.bg_colour = 3'd1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (13) @(negedge clock);
    chk("mid_plot",  {31'd0, bus.plot}, 32'd1);
    chk("mid_x",     {24'd0, bus.x}, 32'd7);
    chk("mid_y",     {25'd0, bus.y}, 32'd7);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_plot", {31'd0, bus.plot}, 32'd0);
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_done", {31'd0, bus.done}, 32'd0);
    chk("arst_x",    {24'd0, bus.x}, 32'd0);
    @(negedge clock);
    reset    = 1'b0;
    plot_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (bus.plot === 1'b1) plot_cnt++;
      if (bus.done === 1'b1) done_cnt++;
    end
    chk("post_rst_plots", 32'(plot_cnt), 32'd0);
    chk("post_rst_dones", 32'(done_cnt), 32'd0);
    chk("post_rst_busy",  {31'd0, bus.busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
